// File: rtl/clk_enable_gen.sv
// clk_enable_gen: synchronous multi-channel clock-enable generator.
//
// Each channel counts system clocks and emits a one-cycle tick every div_eff
// cycles. Each channel also emits a square wave that toggles on every tick.
// Consumers use tick[] as clock enables on clk. Channel 0 drives the CPU and
// can be frozen and single-stepped for debug.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   run       global count enable
//   sync_clr  synchronous resync: clears all counters, ticks and square waves
//   cfg_we    divisor write strobe
//   cfg_sel   channel index for the write (indices >= NCH are ignored)
//   cfg_div   new divisor; 0 behaves as 1
//   dbg_hold  freeze channel 0 counting
//   dbg_step  single-step request for channel 0 (level; rising edge used)
//   tick      registered one-cycle enable strobe per channel
//   sq        registered ~50% square wave per channel
module clk_enable_gen #(
  parameter int unsigned          NCH      = 3,
  parameter int unsigned          CNT_W    = 26,
  parameter logic [NCH*CNT_W-1:0] DIV_INIT = {26'd500000, 26'd50000, 26'd25000000}
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   run,
  input  logic                                   sync_clr,
  input  logic                                   cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]                       cfg_div,
  input  logic                                   dbg_hold,
  input  logic                                   dbg_step,
  output logic [NCH-1:0]                         tick,
  output logic [NCH-1:0]                         sq
);

  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [CNT_W-1:0] div_q   [NCH];
  logic [CNT_W-1:0] div_d   [NCH];
  logic [CNT_W-1:0] div_eff [NCH];
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   sq_q, sq_d;
  logic             step_q;
  logic             step_rise;

  assign step_rise = dbg_step & ~step_q;

  always_comb begin
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      div_eff[i] = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];

      if (cfg_we && (32'(cfg_sel) == 32'(i))) begin
        // A write restarts the period but leaves the square-wave phase alone.
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
      end else if (sync_clr) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if ((i == 0) && dbg_hold) begin
        // Counter frozen; each step edge produces exactly one tick.
        tick_d[i] = step_rise;
        if (step_rise) begin
          sq_d[i] = ~sq_q[i];
        end
      end else if (run) begin
        // >= rather than == so an out-of-range count always wraps.
        if (cnt_q[i] >= div_eff[i] - CNT_W'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      tick_q <= '0;
      sq_q   <= '0;
      step_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
      step_q <= dbg_step;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen (NCH=3, CNT_W=8, divisors 4/5/10).
// Per-channel tick/sq values are shifted into history words one bit per
// clock (oldest bit first) and compared against hand-derived patterns.
module tb_clk_enable_gen;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       sync_clr;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_div;
  logic       dbg_hold;
  logic       dbg_step;
  logic [2:0] tick;
  logic [2:0] sq;

  int errors = 0;
  int checks = 0;

  logic [31:0] h_tick [3];
  logic [31:0] h_sq   [3];

  clk_enable_gen #(
    .NCH      (3),
    .CNT_W    (8),
    .DIV_INIT ({8'd10, 8'd5, 8'd4})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .dbg_hold (dbg_hold),
    .dbg_step (dbg_step),
    .tick     (tick),
    .sq       (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int c = 0; c < 3; c++) begin
      h_tick[c] = '0;
      h_sq[c]   = '0;
    end
  endtask

  // One rising edge, then sample 1 time unit later and record history.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      h_tick[c] = {h_tick[c][30:0], tick[c]};
      h_sq[c]   = {h_sq[c][30:0], sq[c]};
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] div);
    cfg_we  = 1'b1;
    cfg_sel = sel;
    cfg_div = div;
    cycle();
    cfg_we  = 1'b0;
  endtask

  // 20 edges after reset release with default divisors 4/5/10.
  task automatic check_default_periods(input string pfx);
    clear_hist();
    repeat (20) cycle();
    check({pfx, "_tick0"}, h_tick[0], 32'b00010001000100010001);
    check({pfx, "_tick1"}, h_tick[1], 32'b00001000010000100001);
    check({pfx, "_tick2"}, h_tick[2], 32'b00000000010000000001);
    check({pfx, "_sq0"},   h_sq[0],   32'b00011110000111100001);
    check({pfx, "_sq1"},   h_sq[1],   32'b00001111100000111110);
    check({pfx, "_sq2"},   h_sq[2],   32'b00000000011111111110);
  endtask

  initial begin
    rst_n    = 1'b0;
    run      = 1'b1;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_sel  = 2'd0;
    cfg_div  = 8'd0;
    dbg_hold = 1'b0;
    dbg_step = 1'b0;
    clear_hist();

    repeat (2) @(posedge clk);
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq",   32'(sq),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edges 1..20
    check_default_periods("init");

    // Edges 21..23: ch1 reaches cnt=3, then write div=2 at edge 24
    repeat (3) cycle();
    clear_hist();
    cfg_write(2'd1, 8'd2);
    repeat (9) cycle();
    check("wr2_tick1", h_tick[1], 32'b0010101010);
    check("wr2_sq1",   h_sq[1],   32'b0011001100);
    check("wr2_tick0", h_tick[0], 32'b1000100010);
    check("wr2_tick2", h_tick[2], 32'b0000001000);

    // Edges 34..41: div=0 acts as 1
    clear_hist();
    cfg_write(2'd1, 8'd0);
    repeat (7) cycle();
    check("wr0_tick1", h_tick[1], 32'b01111111);
    check("wr0_sq1",   h_sq[1],   32'b01010101);
    check("wr0_tick0", h_tick[0], 32'b00100010);
    check("wr0_tick2", h_tick[2], 32'b00000010);

    // Edges 42..51: out-of-range select is ignored
    clear_hist();
    cfg_write(2'd3, 8'd1);
    repeat (9) cycle();
    check("sel3_tick0", h_tick[0], 32'b0010001000);
    check("sel3_tick1", h_tick[1], 32'b1111111111);
    check("sel3_tick2", h_tick[2], 32'b0000000010);
    check("sel3_sq0",   h_sq[0],   32'b0011110000);

    // Edges 52..54 bring cnt0 to 2; run low for edges 55..61
    repeat (3) cycle();
    clear_hist();
    run = 1'b0;
    repeat (7) cycle();
    run = 1'b1;
    repeat (3) cycle();
    check("run_tick0", h_tick[0], 32'b0000000010);
    check("run_sq0",   h_sq[0],   32'b1111111100);
    check("run_tick1", h_tick[1], 32'b0000000111);
    check("run_sq1",   h_sq[1],   32'b0000000101);
    check("run_tick2", h_tick[2], 32'b0000000000);

    // Edge 65 restores ch1 div=5; sync_clr at edge 66, observe to 76
    cfg_write(2'd1, 8'd5);
    clear_hist();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    check("clr_tick", 32'(tick), 32'd0);
    check("clr_sq",   32'(sq),   32'd0);
    repeat (10) cycle();
    check("clr_tick0", h_tick[0], 32'b00001000100);
    check("clr_tick1", h_tick[1], 32'b00000100001);
    check("clr_tick2", h_tick[2], 32'b00000000001);
    check("clr_sq0",   h_sq[0],   32'b00001111000);
    check("clr_sq1",   h_sq[1],   32'b00000111110);
    check("clr_sq2",   h_sq[2],   32'b00000000001);

    // Edges 77..91: hold ch0, two 5-cycle step pulses
    clear_hist();
    dbg_hold = 1'b1;
    cycle();
    dbg_step = 1'b1;
    repeat (5) cycle();
    dbg_step = 1'b0;
    repeat (2) cycle();
    dbg_step = 1'b1;
    repeat (5) cycle();
    dbg_step = 1'b0;
    repeat (2) cycle();
    check("step_tick0", h_tick[0], 32'b010000001000000);
    check("step_sq0",   h_sq[0],   32'b011111110000000);
    check("step_tick1", h_tick[1], 32'b000010000100001);
    check("step_tick2", h_tick[2], 32'b000000000100000);

    // Edges 92..97: resume from frozen cnt0=2; step without hold ignored
    clear_hist();
    dbg_hold = 1'b0;
    repeat (2) cycle();
    dbg_step = 1'b1;
    repeat (2) cycle();
    dbg_step = 1'b0;
    repeat (2) cycle();
    check("resume_tick0", h_tick[0], 32'b010001);
    check("resume_sq0",   h_sq[0],   32'b011110);

    // Runtime write ch0 div=2, then async reset between edges
    cfg_write(2'd0, 8'd2);
    repeat (2) cycle();
    check("pre_rst_tick0", 32'(tick[0]), 32'd1);
    check("pre_rst_sq0",   32'(sq[0]),   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_sq",   32'(sq),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_default_periods("rerst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised, fully synchronous successor to the free-running ripple clock divider.
- Produces NCH independent clock-enable strobes and matching square-wave outputs from the single system clock.
- Each divisor is programmable at run time, with global run/resync control and a single-step debug mode on channel 0, which drives the CPU.
- Downstream logic consumes tick[] as clock enables on clk, not as derived clocks.

Parameters:
- NCH, 3, number of channels. Channel 0 = CPU enable, 1 = 1 kHz, 2 = 100 Hz.
- CNT_W, 26, counter and divisor width per channel.
- DIV_INIT, {26'd500000, 26'd50000, 26'd25000000}, packed NCH*CNT_W reset divisors. Channel i occupies bits [i*CNT_W +: CNT_W]. Defaults target a 50 MHz clk.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  global count enable.
- sync_clr  in  1  synchronous resync of all channels.
- cfg_we  in  1  divisor write strobe.
- cfg_sel  in  $clog2(NCH) (min 1)  channel index for the write.
- cfg_div  in  CNT_W  new divisor value.
- dbg_hold  in  1  freeze channel 0 (CPU) counting.
- dbg_step  in  1  single-step request for channel 0; level input, rising edge detected internally.
- tick  out  NCH  one-clk-wide enable strobe per channel, registered.
- sq  out  NCH  ~50% square wave per channel, registered; toggles on each tick.

Behaviour:
- Reset (rst_n=0, async):
  - cnt[i]=0, div[i]=DIV_INIT[i], tick=0, sq=0, step_q=0.
- Divisor rules:
  - Effective divisor div_eff = (div==0) ? 1 : div.
  - tick period = div_eff clk cycles; sq period = 2*div_eff.
- Per channel, each clk edge, in priority order:
  1. cfg_we && cfg_sel==i: div[i]<=cfg_div, cnt[i]<=0, tick[i]<=0, sq[i] holds. Takes priority even over sync_clr for this channel.
  2. sync_clr: cnt<=0, tick<=0, sq<=0.
  3. i==0 && dbg_hold: cnt[0] holds. tick[0]<=step_rise; sq[0] toggles when step_rise.
  4. run==0: cnt holds, tick<=0, sq holds.
  5. Otherwise, if cnt>=div_eff-1: cnt<=0, tick<=1, sq<=~sq. Else cnt<=cnt+1, tick<=0.
- The >= compare guarantees recovery if a smaller divisor is written while cnt is above it (defensive; a write already clears cnt).
- Timing from cnt=0 with run=1: tick first high after div_eff rising edges, then every div_eff cycles. div=1 gives tick constantly high and sq toggling every cycle.
- cfg_sel>=NCH: write ignored, no side effects.
- Single-step:
  - step_q registers dbg_step each cycle; step_rise = dbg_step & ~step_q.
  - One step produces exactly one tick[0] cycle regardless of how long dbg_step is held.
  - Step while dbg_hold=0 is ignored; step_q still tracks.
  - Step is honoured even when run=0, but not during sync_clr.
- dbg_hold deassert: channel 0 resumes counting from its frozen cnt value; no extra tick.
- Channels are independent; an write to one channel never disturbs another.
- Reset mid-period: all outputs drop to 0 immediately (async) and restart from cnt=0 with DIV_INIT divisors, discarding any runtime writes.
- No combinational path from any input to tick or sq.

Test Plan (bench params: NCH=3, CNT_W=8, DIV_INIT={8'd10, 8'd5, 8'd4}):
- Release rst_n with run=1 -> tick[0] high 1 cycle at edges 4, 8, 12…; tick[1] every 5 cycles; tick[2] every 10; sq[0] period 8, sq[1] period 10.
- cfg_we, cfg_sel=1, cfg_div=2 mid-period (cnt[1]=3) -> cnt[1]=0 next cycle; tick[1] 2 cycles later, then every 2; channels 0 and 2 unaffected. Repeat with cfg_div=0 -> tick[1] continuously high. cfg_sel=3 -> no change anywhere.
- run=0 for 7 cycles starting at cnt[0]=2 -> tick=0, sq holds; after run=1, tick[0] after exactly 2 more edges.
- sync_clr pulse with all channels mid-count -> all cnt, tick and sq = 0 next cycle; all channels then phase-aligned, with the first tick[0] 4 edges later.
- dbg_hold=1, dbg_step held high 5 cycles, twice -> exactly 2 single-cycle tick[0] pulses, sq[0] toggled twice, cnt[0] unchanged, channels 1 and 2 keep counting. Step with hold=0 -> no extra tick.
- Assert rst_n=0 asynchronously between edges after runtime writes -> tick and sq drop to 0 at once; after release, periods revert to 4/5/10.
